replay_command_fifo: RTL and testbench

- Parametrised command FIFO. It adds a retention window, so commands already issued can be re-issued N times for replay iterations without the producer re-sending them.
- Sits between the command generator and the PE-array command decoder.
- Normal mode behaves as a synchronous FIFO with registered read data.
- Replay mode rewinds the read pointer to the oldest retained entry and re-streams the retained window for the requested number of passes.

---
 rtl/replay_command_fifo_pkg.sv | 15 +
 rtl/replay_fifo_ram.sv | 35 +++
 rtl/replay_command_fifo.sv | 153 +++++++++++++++
 tb/tb_replay_command_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/replay_command_fifo_pkg.sv
// Shared command/FIFO types and default sizing for the replay command path.
package replay_command_fifo_pkg;

  localparam int unsigned COM_DATA_W     = 32;
  localparam int unsigned COM_FIFO_DEPTH = 16;
  localparam int unsigned COM_ITER_W     = 8;

  typedef logic [COM_DATA_W-1:0] com_packet;

  typedef enum logic {
    NORMAL = 1'b0,
    REPLAY = 1'b1
  } replay_state_e;

endpackage : replay_command_fifo_pkg

// File: rtl/replay_fifo_ram.sv
// Simple dual-port command store: one write port, one registered read port
// whose output returns to zero on cycles without a read.
module replay_fifo_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[raddr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule : replay_fifo_ram

// File: rtl/replay_command_fifo.sv
// Command FIFO with a retention window [mark_ptr, wr_ptr) that can be
// re-streamed a requested number of times before being released.
module replay_command_fifo
  import replay_command_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = $bits(com_packet),
  parameter int unsigned DEPTH    = COM_FIFO_DEPTH,
  parameter int unsigned ITER_W   = COM_ITER_W,
  parameter int unsigned AFULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic                       rd_en,
  output logic                       rd_avail,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       replay_start,
  input  logic [ITER_W-1:0]          replay_iters,
  input  logic                       release_en,
  output logic                       replay_busy,
  output logic                       pass_done,
  output logic                       replay_done,
  output logic [$clog2(DEPTH):0]     retained_cnt,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  replay_state_e     state, state_nx;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nx;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nx;
  logic [PTR_W-1:0]  mark_ptr, mark_ptr_nx;
  logic [ITER_W-1:0] passes, passes_nx;
  logic              rd_valid_nx, pass_done_nx, replay_done_nx, overflow_nx;

  logic full;
  logic push;
  logic pop;
  logic start;
  logic last_entry;

  // Window occupancy and handshake derived from the registered pointers
  assign retained_cnt = wr_ptr - mark_ptr;
  assign full         = (retained_cnt == PTR_W'(DEPTH));
  assign almost_full  = (retained_cnt >= PTR_W'(AFULL_TH));
  assign wr_ready     = (state == NORMAL) && !full;
  assign rd_avail     = (rd_ptr != wr_ptr);
  assign replay_busy  = (state == REPLAY);

  assign push       = wr_en && wr_ready;
  assign start      = (state == NORMAL) && replay_start &&
                      (replay_iters != '0) && (retained_cnt != '0);
  // A pop requested in the same cycle a replay begins is discarded
  assign pop        = rd_en && rd_avail && !start;
  assign last_entry = ((rd_ptr + PTR_W'(1)) == wr_ptr);

  always_comb begin
    state_nx       = state;
    wr_ptr_nx      = wr_ptr;
    rd_ptr_nx      = rd_ptr;
    mark_ptr_nx    = mark_ptr;
    passes_nx      = passes;
    overflow_nx    = overflow;
    rd_valid_nx    = pop;
    pass_done_nx   = 1'b0;
    replay_done_nx = 1'b0;

    if (push) begin
      wr_ptr_nx = wr_ptr + PTR_W'(1);
    end
    if ((state == NORMAL) && wr_en && !wr_ready) begin
      overflow_nx = 1'b1;
    end

    case (state)
      NORMAL: begin
        if (start) begin
          state_nx  = REPLAY;
          rd_ptr_nx = mark_ptr;
          passes_nx = replay_iters;
        end else begin
          if (pop) begin
            rd_ptr_nx = rd_ptr + PTR_W'(1);
          end
          if (release_en) begin
            mark_ptr_nx = rd_ptr;
          end
        end
      end
      REPLAY: begin
        if (pop) begin
          if (!last_entry) begin
            rd_ptr_nx = rd_ptr + PTR_W'(1);
          end else if (passes > ITER_W'(1)) begin
            rd_ptr_nx    = mark_ptr;
            passes_nx    = passes - ITER_W'(1);
            pass_done_nx = 1'b1;
          end else begin
            rd_ptr_nx      = wr_ptr;
            passes_nx      = '0;
            state_nx       = NORMAL;
            replay_done_nx = 1'b1;
          end
        end
      end
      default: state_nx = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= NORMAL;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mark_ptr    <= '0;
      passes      <= '0;
      rd_valid    <= 1'b0;
      pass_done   <= 1'b0;
      replay_done <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_ptr      <= wr_ptr_nx;
      rd_ptr      <= rd_ptr_nx;
      mark_ptr    <= mark_ptr_nx;
      passes      <= passes_nx;
      rd_valid    <= rd_valid_nx;
      pass_done   <= pass_done_nx;
      replay_done <= replay_done_nx;
      overflow    <= overflow_nx;
    end
  end

  replay_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (push),
    .waddr   (wr_ptr[ADDR_W-1:0]),
    .wdata   (wr_data),
    .re      (pop),
    .raddr   (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule : replay_command_fifo

// File: tb/tb_replay_command_fifo.sv
// Directed bench for replay_command_fifo at DEPTH=4, DATA_W=8, ITER_W=8.
module tb_replay_command_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_en;
  logic       rd_avail;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       replay_start;
  logic [7:0] replay_iters;
  logic       release_en;
  logic       replay_busy;
  logic       pass_done;
  logic       replay_done;
  logic [2:0] retained_cnt;
  logic       almost_full;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  replay_command_fifo #(
    .DATA_W   (8),
    .DEPTH    (4),
    .ITER_W   (8),
    .AFULL_TH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_en        (rd_en),
    .rd_avail     (rd_avail),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .replay_start (replay_start),
    .replay_iters (replay_iters),
    .release_en   (release_en),
    .replay_busy  (replay_busy),
    .pass_done    (pass_done),
    .replay_done  (replay_done),
    .retained_cnt (retained_cnt),
    .almost_full  (almost_full),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 1);
    chk({tag, "_rd_avail"}, 32'(rd_avail), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_retained"}, 32'(retained_cnt), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_busy"}, 32'(replay_busy), 0);
    chk({tag, "_pass_done"}, 32'(pass_done), 0);
    chk({tag, "_replay_done"}, 32'(replay_done), 0);
  endtask

  initial begin
    logic [7:0] fill [4];
    logic [7:0] rep  [8];
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};
    rep  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};

    reset = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    replay_start = 1'b0; replay_iters = '0; release_en = 1'b0;
    #3;
    check_idle_reset("reset");
    #4 reset = 1'b1;
    tick();

    // Fill to full, checking the almost_full boundary on the way
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = fill[i];
      tick();
      if (i == 0) chk("afull_at_1", 32'(almost_full), 0);
      if (i == 1) chk("afull_at_2", 32'(almost_full), 1);
    end
    chk("full_wr_ready", 32'(wr_ready), 0);
    chk("full_retained", 32'(retained_cnt), 4);
    chk("full_afull", 32'(almost_full), 1);
    chk("full_overflow_clear", 32'(overflow), 0);
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    chk("overflow_set", 32'(overflow), 1);
    chk("overflow_retained", 32'(retained_cnt), 4);

    // Drain in normal mode
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pop_valid", 32'(rd_valid), 1);
      chk("pop_data", 32'(rd_data), 32'(fill[i]));
    end
    chk("drained_avail", 32'(rd_avail), 0);
    tick();
    chk("empty_pop_valid", 32'(rd_valid), 0);
    chk("empty_pop_data", 32'(rd_data), 0);
    rd_en = 1'b0;

    // Two-pass replay of the retained window
    replay_start = 1'b1; replay_iters = 8'd2;
    tick();
    replay_start = 1'b0;
    chk("rep_busy", 32'(replay_busy), 1);
    chk("rep_wr_ready", 32'(wr_ready), 0);
    chk("rep_start_valid", 32'(rd_valid), 0);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rep_valid", 32'(rd_valid), 1);
      chk("rep_data", 32'(rd_data), 32'(rep[i]));
      chk("rep_pass_done", 32'(pass_done), (i == 3) ? 1 : 0);
      chk("rep_replay_done", 32'(replay_done), (i == 7) ? 1 : 0);
      chk("rep_busy_run", 32'(replay_busy), (i == 7) ? 0 : 1);
    end
    rd_en = 1'b0;
    tick();
    chk("post_rep_valid", 32'(rd_valid), 0);
    chk("post_rep_retained", 32'(retained_cnt), 4);
    chk("post_rep_busy", 32'(replay_busy), 0);

    // Release, then push across the address wrap and replay once
    release_en = 1'b1;
    tick();
    release_en = 1'b0;
    chk("rel_retained", 32'(retained_cnt), 0);
    chk("rel_wr_ready", 32'(wr_ready), 1);
    chk("rel_afull", 32'(almost_full), 0);
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    chk("wrap_retained", 32'(retained_cnt), 2);
    chk("wrap_avail", 32'(rd_avail), 1);
    replay_start = 1'b1; replay_iters = 8'd1;
    tick();
    replay_start = 1'b0;
    chk("wrap_busy", 32'(replay_busy), 1);
    rd_en = 1'b1;
    tick();
    chk("wrap_data0", 32'(rd_data), 32'h55);
    chk("wrap_pd0", 32'(pass_done), 0);
    tick();
    rd_en = 1'b0;
    chk("wrap_data1", 32'(rd_data), 32'h66);
    chk("wrap_done", 32'(replay_done), 1);
    chk("wrap_idle", 32'(replay_busy), 0);
    chk("wrap_avail_end", 32'(rd_avail), 0);
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    chk("wrap_push_retained", 32'(retained_cnt), 3);
    tick();
    rd_en = 1'b0;
    chk("wrap_pop_data", 32'(rd_data), 32'h77);

    // Replay requests that must not start
    replay_start = 1'b1; replay_iters = 8'd0;
    tick();
    replay_start = 1'b0;
    chk("iters0_busy", 32'(replay_busy), 0);
    chk("iters0_pd", 32'(pass_done), 0);
    chk("iters0_rd", 32'(replay_done), 0);
    release_en = 1'b1;
    tick();
    release_en = 1'b0;
    chk("empty_win_retained", 32'(retained_cnt), 0);
    replay_start = 1'b1; replay_iters = 8'd5;
    tick();
    replay_start = 1'b0;
    chk("empty_win_busy", 32'(replay_busy), 0);
    chk("empty_win_rd", 32'(replay_done), 0);

    // Replay start with a same-cycle pop request
    wr_en = 1'b1; wr_data = 8'h88;
    tick();
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    replay_start = 1'b1; replay_iters = 8'd1; rd_en = 1'b1;
    tick();
    replay_start = 1'b0;
    chk("start_pop_busy", 32'(replay_busy), 1);
    chk("start_pop_valid", 32'(rd_valid), 0);
    tick();
    chk("start_pop_data0", 32'(rd_data), 32'h88);
    tick();
    rd_en = 1'b0;
    chk("start_pop_data1", 32'(rd_data), 32'h99);
    chk("start_pop_done", 32'(replay_done), 1);

    // Reset in the middle of a three-pass replay
    replay_start = 1'b1; replay_iters = 8'd3;
    tick();
    replay_start = 1'b0; rd_en = 1'b1;
    tick();
    tick();
    chk("mid_pass_done", 32'(pass_done), 1);
    chk("mid_busy", 32'(replay_busy), 1);
    reset = 1'b0;
    #1;
    rd_en = 1'b0;
    check_idle_reset("mid_reset");
    tick();
    reset = 1'b1;
    tick();
    chk("after_reset_busy", 32'(replay_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_replay_command_fifo
